// File: rtl/rob_commit_arbiter_pkg.sv
// Shared widths and helpers for the commit-side arbiter and the decode side.
package rob_commit_arbiter_pkg;

  // Ceiling log2, minimum result 0; used for every derived index width.
  function automatic int clogb(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int INFO_LENGTH    = 20;
  localparam int ORDER_ID       = 3;
  localparam int DATA_LENGTH    = 512;
  localparam int REGISTER_NUM   = 32;
  localparam int NUM_ROB        = 7;

  localparam int REGISTER_WIDTH = clogb(REGISTER_NUM);
  localparam int ROB_WIDTH      = clogb(NUM_ROB);

  // Output buffer depth; the grant rule keeps s1 plus buffer within this.
  localparam int OUT_FIFO_DEPTH    = 2;
  localparam int OUT_FIFO_CNT_WIDTH = clogb(OUT_FIFO_DEPTH + 1);

endpackage

// File: rtl/commit_out_fifo.sv
// Small synchronous FIFO holding committed {id, info, data} packets.
module commit_out_fifo
  import rob_commit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          i_srst,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_push_data,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_pop_data,
  output logic [OUT_FIFO_CNT_WIDTH-1:0] o_count
);

  localparam int PTR_W = (clogb(OUT_FIFO_DEPTH) < 1) ? 1 : clogb(OUT_FIFO_DEPTH);

  logic [WIDTH-1:0]              r_mem [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [OUT_FIFO_CNT_WIDTH-1:0] r_count;
  logic                          w_do_pop;
  logic                          w_do_push;
  logic                          w_full;

  assign w_full    = (r_count == OUT_FIFO_CNT_WIDTH'(OUT_FIFO_DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full buffer is accepted only when a pop frees a slot.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // The upstream grant rule must never push into a full buffer without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (i_srst)
    !(i_push && w_full && !w_do_pop));

endmodule

// File: rtl/rob_commit_arbiter.sv
// Commit scheduler: round-robin pop of finished ROB heads, register read,
// register release and in-order delivery through a small output buffer.
module rob_commit_arbiter
  import rob_commit_arbiter_pkg::*;
#(
  parameter int info_length  = INFO_LENGTH,
  parameter int order_id     = ORDER_ID,
  parameter int data_length  = DATA_LENGTH,
  parameter int register_num = REGISTER_NUM,
  parameter int num_rob      = NUM_ROB
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [num_rob-1:0]                      rob_done_i,
  input  logic [num_rob*clogb(register_num)-1:0]  rob_reg_entry_i,
  input  logic [num_rob*info_length-1:0]          rob_info_i,
  output logic [num_rob-1:0]                      rob_rd_o,
  output logic                                    reg_rd_en_o,
  output logic [clogb(register_num)-1:0]          reg_rd_addr_o,
  input  logic [data_length-1:0]                  reg_rd_data_i,
  output logic                                    reg_free_o,
  output logic [clogb(register_num)-1:0]          reg_free_addr_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic [order_id-1:0]                     out_id_o,
  output logic [info_length-1:0]                  out_info_o,
  output logic [data_length-1:0]                  out_data_o
);

  localparam int REG_W = clogb(register_num);
  localparam int PTR_W = (clogb(num_rob) < 1) ? 1 : clogb(num_rob);
  localparam int PKT_W = order_id + info_length + data_length;

  // Per-ROB views of the packed head buses.
  logic [REG_W-1:0]       w_head_reg  [num_rob];
  logic [info_length-1:0] w_head_info [num_rob];

  genvar gi;
  generate
    for (gi = 0; gi < num_rob; gi++) begin : g_unpack
      assign w_head_reg[gi]  = rob_reg_entry_i[gi*REG_W +: REG_W];
      assign w_head_info[gi] = rob_info_i[gi*info_length +: info_length];
    end
  endgenerate

  logic [PTR_W-1:0]              r_rr_ptr;
  logic                          r_s1_valid;
  logic [order_id-1:0]           r_s1_id;
  logic [info_length-1:0]        r_s1_info;
  logic [REG_W-1:0]              r_s1_reg;

  logic                          w_grant;
  logic [PTR_W-1:0]              w_grant_idx;
  logic [PTR_W-1:0]              w_ptr_next;
  logic [order_id-1:0]           w_grant_id;
  logic                          w_space_ok;
  logic                          w_out_valid;
  logic                          w_fire;
  logic                          w_push;
  logic [PKT_W-1:0]              w_push_data;
  logic [PKT_W-1:0]              w_head_pkt;
  logic [OUT_FIFO_CNT_WIDTH-1:0] w_fifo_count;

  // Output side: a packet is visible whenever the buffer holds one.
  assign w_out_valid = (w_fifo_count != '0) && !rst;
  assign w_fire      = w_out_valid && out_ready_i;

  // Everything granted but not yet accepted (s1 plus buffer) must fit after
  // this cycle's pop, so a new grant can always land in the buffer.
  assign w_space_ok = (int'(w_fifo_count) + int'(r_s1_valid)) < (OUT_FIFO_DEPTH + int'(w_fire));

  // Rotating-priority search starting at the round-robin pointer.
  always_comb begin
    int idx;
    w_grant     = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int i = 0; i < num_rob; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= num_rob) begin
        idx = idx - num_rob;
      end
      if (!w_grant && !rst && w_space_ok && rob_done_i[PTR_W'(idx)]) begin
        w_grant     = 1'b1;
        w_grant_idx = PTR_W'(idx);
      end
    end
  end

  assign w_ptr_next = (w_grant_idx == PTR_W'(num_rob - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_grant_id = order_id'(int'(w_grant_idx) + 1);

  // One-hot pop pulse to the granted ROB.
  always_comb begin
    rob_rd_o = '0;
    if (w_grant) begin
      rob_rd_o[w_grant_idx] = 1'b1;
    end
  end

  assign reg_rd_en_o   = w_grant;
  assign reg_rd_addr_o = w_grant ? w_head_reg[w_grant_idx] : '0;

  // Pointer advance and s1 capture of the granted head's side-band.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_grant;
      if (w_grant) begin
        r_rr_ptr  <= w_ptr_next;
        r_s1_id   <= w_grant_id;
        r_s1_info <= w_head_info[w_grant_idx];
        r_s1_reg  <= w_head_reg[w_grant_idx];
      end
    end
  end

  // s1 is discarded under reset, so its register is not released either.
  assign reg_free_o      = r_s1_valid && !rst;
  assign reg_free_addr_o = reg_free_o ? r_s1_reg : '0;

  assign w_push      = r_s1_valid && !rst;
  assign w_push_data = {r_s1_id, r_s1_info, reg_rd_data_i};

  commit_out_fifo #(
    .WIDTH (PKT_W)
  ) u_out_fifo (
    .clk         (clk),
    .i_srst      (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_fire),
    .o_pop_data  (w_head_pkt),
    .o_count     (w_fifo_count)
  );

  assign out_valid_o = w_out_valid;
  assign out_id_o    = w_out_valid ? w_head_pkt[PKT_W-1 -: order_id] : '0;
  assign out_info_o  = w_out_valid ? w_head_pkt[data_length +: info_length] : '0;
  assign out_data_o  = w_out_valid ? w_head_pkt[data_length-1:0] : '0;

endmodule

// File: tb/tb_rob_commit_arbiter.sv
// Self-checking bench for rob_commit_arbiter: directed scenarios plus a
// randomized run against a packet-queue reference model.
module tb_rob_commit_arbiter;

  localparam int NR = 7;
  localparam int RW = 5;
  localparam int IW = 20;
  localparam int DW = 512;
  localparam int QD = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   rob_done_i;
  logic [NR*RW-1:0] rob_reg_entry_i;
  logic [NR*IW-1:0] rob_info_i;
  logic [NR-1:0]   rob_rd_o;
  logic            reg_rd_en_o;
  logic [RW-1:0]   reg_rd_addr_o;
  logic [DW-1:0]   reg_rd_data_i;
  logic            reg_free_o;
  logic [RW-1:0]   reg_free_addr_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [2:0]      out_id_o;
  logic [IW-1:0]   out_info_o;
  logic [DW-1:0]   out_data_o;

  rob_commit_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .rob_done_i      (rob_done_i),
    .rob_reg_entry_i (rob_reg_entry_i),
    .rob_info_i      (rob_info_i),
    .rob_rd_o        (rob_rd_o),
    .reg_rd_en_o     (reg_rd_en_o),
    .reg_rd_addr_o   (reg_rd_addr_o),
    .reg_rd_data_i   (reg_rd_data_i),
    .reg_free_o      (reg_free_o),
    .reg_free_addr_o (reg_free_addr_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_id_o        (out_id_o),
    .out_info_o      (out_info_o),
    .out_data_o      (out_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    id;
    logic [IW-1:0] info;
    logic [DW-1:0] data;
    int            vis;
  } pkt_t;

  int n_vec = 0;
  int n_err = 0;

  // Environment: ROB contents, register file, and flow-control knobs.
  logic [RW-1:0] rob_reg_mem  [NR][QD];
  logic [IW-1:0] rob_info_mem [NR][QD];
  int            rob_head [NR];
  int            rob_tail [NR];
  logic [DW-1:0] reg_mem  [32];
  logic [NR-1:0] done_mask;
  logic          ready_v;
  logic          rd_pending;
  logic [RW-1:0] rd_addr_pend;

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_rob(input int k, input logic [RW-1:0] r, input logic [IW-1:0] info);
    rob_reg_mem[k][rob_tail[k] % QD]  = r;
    rob_info_mem[k][rob_tail[k] % QD] = info;
    rob_tail[k]++;
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < NR; k++) begin
      if (rob_tail[k] != rob_head[k]) begin
        rob_done_i[k]             = done_mask[k];
        rob_reg_entry_i[k*RW +: RW] = rob_reg_mem[k][rob_head[k] % QD];
        rob_info_i[k*IW +: IW]    = rob_info_mem[k][rob_head[k] % QD];
      end else begin
        rob_done_i[k]             = 1'b0;
        rob_reg_entry_i[k*RW +: RW] = RW'($urandom);
        rob_info_i[k*IW +: IW]    = IW'($urandom);
      end
    end
    out_ready_i   = ready_v;
    reg_rd_data_i = rd_pending ? reg_mem[rd_addr_pend] : rand512();
  endtask

  // Advance one clock: ROBs pop on the pulses seen, the register file answers
  // the read one cycle later, then inputs are re-driven past the falling edge.
  task automatic tick();
    logic [NR-1:0] g;
    logic          en;
    logic [RW-1:0] a;
    g  = rob_rd_o;
    en = reg_rd_en_o;
    a  = reg_rd_addr_o;
    @(posedge clk);
    for (int k = 0; k < NR; k++) begin
      if (g[k] && rob_head[k] != rob_tail[k]) rob_head[k]++;
    end
    rd_pending   = en;
    rd_addr_pend = a;
    @(negedge clk);
    apply_inputs();
    #1;
  endtask

  task automatic clear_env();
    for (int k = 0; k < NR; k++) begin
      rob_head[k] = 0;
      rob_tail[k] = 0;
    end
    done_mask  = '1;
    ready_v    = 1'b0;
    rd_pending = 1'b0;
  endtask

  task automatic reset_dut();
    clear_env();
    rst = 1'b1;
    apply_inputs();
    tick();
    tick();
    rst = 1'b0;
    apply_inputs();
    #1;
  endtask

  task automatic test_reset();
    clear_env();
    ready_v = 1'b1;
    push_rob(1, 5'd3, 20'h11111);
    push_rob(6, 5'd4, 20'h66666);
    rst = 1'b1;
    apply_inputs();
    tick();
    tick();
    n_vec++; if (rob_rd_o !== 7'b0) begin n_err++; $display("FAIL reset_rob_rd: got %b required 0", rob_rd_o); end
    n_vec++; if (reg_rd_en_o !== 1'b0 || reg_rd_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_rd: got en=%b addr=%0d required 0/0", reg_rd_en_o, reg_rd_addr_o); end
    n_vec++; if (reg_free_o !== 1'b0 || reg_free_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_free: got %b/%0d required 0/0", reg_free_o, reg_free_addr_o); end
    n_vec++; if (out_valid_o !== 1'b0 || out_id_o !== 3'd0 || out_info_o !== 20'd0 || out_data_o !== '0) begin n_err++; $display("FAIL reset_out: got valid=%b id=%0d info=%0h required zeros", out_valid_o, out_id_o, out_info_o); end
    rst = 1'b0;
    #1;
    n_vec++; if (rob_rd_o !== 7'b0000010) begin n_err++; $display("FAIL reset_first_grant: got %b required 0000010", rob_rd_o); end
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_idle_out: got %b required 0", out_valid_o); end
  endtask

  task automatic test_single_commit();
    logic [DW-1:0] a5;
    a5 = {64{8'hA5}};
    reset_dut();
    reg_mem[5] = a5;
    push_rob(2, 5'd5, 20'h12345);
    ready_v = 1'b1;
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b0000100) begin n_err++; $display("FAIL single_grant: got %b required 0000100", rob_rd_o); end
    n_vec++; if (reg_rd_en_o !== 1'b1 || reg_rd_addr_o !== 5'd5) begin n_err++; $display("FAIL single_rd: got en=%b addr=%0d required 1/5", reg_rd_en_o, reg_rd_addr_o); end
    tick();
    n_vec++; if (rob_rd_o !== 7'b0) begin n_err++; $display("FAIL single_one_pulse: got %b required 0", rob_rd_o); end
    n_vec++; if (reg_free_o !== 1'b1 || reg_free_addr_o !== 5'd5) begin n_err++; $display("FAIL single_free: got %b/%0d required 1/5", reg_free_o, reg_free_addr_o); end
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b required 0", out_valid_o); end
    tick();
    n_vec++; if (out_valid_o !== 1'b1 || out_id_o !== 3'd3) begin n_err++; $display("FAIL single_out: got valid=%b id=%0d required 1/3", out_valid_o, out_id_o); end
    n_vec++; if (out_info_o !== 20'h12345 || out_data_o !== a5) begin n_err++; $display("FAIL single_payload: got info=%0h data=%0h required 12345/%0h", out_info_o, out_data_o, a5); end
    n_vec++; if (reg_free_o !== 1'b0) begin n_err++; $display("FAIL single_free_once: got %b required 0", reg_free_o); end
    tick();
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b required 0", out_valid_o); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_rd;
    logic          exp_v;
    reset_dut();
    for (int k = 0; k < NR; k++) begin
      push_rob(k, 5'(k + 8), 20'(k));
      push_rob(k, 5'(k + 16), 20'(k + 100));
    end
    ready_v = 1'b1;
    apply_inputs();
    #1;
    for (int i = 0; i < 20; i++) begin
      exp_rd = (i < 14) ? 7'(1 << (i % NR)) : 7'b0;
      exp_v  = (i >= 2) && (i - 2 < 14);
      n_vec++; if (rob_rd_o !== exp_rd) begin n_err++; $display("FAIL rr_grant[%0d]: got %b required %b", i, rob_rd_o, exp_rd); end
      n_vec++; if (out_valid_o !== exp_v) begin n_err++; $display("FAIL rr_valid[%0d]: got %b required %b", i, out_valid_o, exp_v); end
      if (exp_v && out_valid_o) begin
        n_vec++; if (out_id_o !== 3'(((i - 2) % NR) + 1)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d required %0d", i, out_id_o, ((i - 2) % NR) + 1); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    reg_mem[10] = rand512();
    reg_mem[11] = rand512();
    reg_mem[12] = rand512();
    push_rob(0, 5'd10, 20'hAAAA1);
    push_rob(1, 5'd11, 20'hBBBB2);
    push_rob(2, 5'd12, 20'hCCCC3);
    ready_v = 1'b0;
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b0000001) begin n_err++; $display("FAIL bp_grant0: got %b required 0000001", rob_rd_o); end
    tick();
    n_vec++; if (rob_rd_o !== 7'b0000010) begin n_err++; $display("FAIL bp_grant1: got %b required 0000010", rob_rd_o); end
    tick();
    n_vec++; if (rob_rd_o !== 7'b0) begin n_err++; $display("FAIL bp_stall_a: got %b required 0", rob_rd_o); end
    tick();
    n_vec++; if (rob_rd_o !== 7'b0) begin n_err++; $display("FAIL bp_stall_b: got %b required 0", rob_rd_o); end
    n_vec++; if (out_valid_o !== 1'b1 || out_id_o !== 3'd1) begin n_err++; $display("FAIL bp_hold: got valid=%b id=%0d required 1/1", out_valid_o, out_id_o); end
    ready_v = 1'b1;
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b0000100) begin n_err++; $display("FAIL bp_fire_and_grant: got %b required 0000100", rob_rd_o); end
    n_vec++; if (out_id_o !== 3'd1 || out_info_o !== 20'hAAAA1 || out_data_o !== reg_mem[10]) begin n_err++; $display("FAIL bp_out1: got id=%0d info=%0h required 1/aaaa1", out_id_o, out_info_o); end
    tick();
    n_vec++; if (out_valid_o !== 1'b1 || out_id_o !== 3'd2 || out_info_o !== 20'hBBBB2 || out_data_o !== reg_mem[11]) begin n_err++; $display("FAIL bp_out2: got valid=%b id=%0d info=%0h required 1/2/bbbb2", out_valid_o, out_id_o, out_info_o); end
    tick();
    n_vec++; if (out_valid_o !== 1'b1 || out_id_o !== 3'd3 || out_info_o !== 20'hCCCC3 || out_data_o !== reg_mem[12]) begin n_err++; $display("FAIL bp_out3: got valid=%b id=%0d info=%0h required 1/3/cccc3", out_valid_o, out_id_o, out_info_o); end
    tick();
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b required 0", out_valid_o); end
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    push_rob(4, 5'd7, 20'h44444);
    ready_v = 1'b1;
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b0010000) begin n_err++; $display("FAIL mid_grant: got %b required 0010000", rob_rd_o); end
    tick();
    rst = 1'b1;
    #1;
    n_vec++; if (reg_free_o !== 1'b0) begin n_err++; $display("FAIL mid_no_free: got %b required 0", reg_free_o); end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (out_valid_o !== 1'b0 || reg_free_o !== 1'b0) begin n_err++; $display("FAIL mid_discard: got valid=%b free=%b required 0/0", out_valid_o, reg_free_o); end
    push_rob(0, 5'd1, 20'h00001);
    push_rob(6, 5'd2, 20'h00006);
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b0000001) begin n_err++; $display("FAIL mid_ptr_reset: got %b required 0000001", rob_rd_o); end
  endtask

  task automatic test_wrap();
    reset_dut();
    push_rob(5, 5'd9, 20'h55555);
    ready_v = 1'b1;
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b0100000) begin n_err++; $display("FAIL wrap_setup: got %b required 0100000", rob_rd_o); end
    tick();
    push_rob(6, 5'd20, 20'h66660);
    push_rob(0, 5'd21, 20'h00000);
    apply_inputs();
    #1;
    n_vec++; if (rob_rd_o !== 7'b1000000) begin n_err++; $display("FAIL wrap_grant6: got %b required 1000000", rob_rd_o); end
    tick();
    n_vec++; if (rob_rd_o !== 7'b0000001) begin n_err++; $display("FAIL wrap_grant0: got %b required 0000001", rob_rd_o); end
  endtask

  // Reference model: every granted packet sits in one ordered queue and is
  // visible two cycles after its grant; queue size is the in-flight count.
  task automatic test_random();
    pkt_t          exp_q[$];
    pkt_t          p;
    int            ptr;
    int            ek;
    int            idx;
    int            k;
    logic          prev_v;
    logic [RW-1:0] prev_reg;
    logic          exp_valid;
    logic          fire;
    logic          allowed;
    logic [NR-1:0] exp_rd;
    logic [RW-1:0] exp_addr;
    reset_dut();
    ptr      = 0;
    prev_v   = 1'b0;
    prev_reg = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      n_vec++; if (out_valid_o !== exp_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b required %b", cyc, out_valid_o, exp_valid); end
      if (exp_valid && out_valid_o) begin
        n_vec++; if (out_id_o !== exp_q[0].id || out_info_o !== exp_q[0].info) begin n_err++; $display("FAIL rnd_hdr[%0d]: got id=%0d info=%0h required %0d/%0h", cyc, out_id_o, out_info_o, exp_q[0].id, exp_q[0].info); end
        n_vec++; if (out_data_o !== exp_q[0].data) begin n_err++; $display("FAIL rnd_data[%0d]: got %0h required %0h", cyc, out_data_o, exp_q[0].data); end
      end
      fire    = exp_valid && ready_v;
      allowed = (exp_q.size() - (fire ? 1 : 0)) < 2;
      ek = -1;
      if (allowed) begin
        for (int i = 0; i < NR; i++) begin
          idx = (ptr + i) % NR;
          if (ek < 0 && rob_done_i[idx]) ek = idx;
        end
      end
      exp_rd   = '0;
      exp_addr = '0;
      if (ek >= 0) begin
        exp_rd[ek] = 1'b1;
        exp_addr   = rob_reg_mem[ek][rob_head[ek] % QD];
      end
      n_vec++; if (rob_rd_o !== exp_rd) begin n_err++; $display("FAIL rnd_grant[%0d]: got %b required %b", cyc, rob_rd_o, exp_rd); end
      n_vec++; if (reg_rd_en_o !== (ek >= 0) || reg_rd_addr_o !== exp_addr) begin n_err++; $display("FAIL rnd_rd[%0d]: got %b/%0d required %b/%0d", cyc, reg_rd_en_o, reg_rd_addr_o, ek >= 0, exp_addr); end
      n_vec++; if (reg_free_o !== prev_v || reg_free_addr_o !== (prev_v ? prev_reg : 5'd0)) begin n_err++; $display("FAIL rnd_free[%0d]: got %b/%0d required %b/%0d", cyc, reg_free_o, reg_free_addr_o, prev_v, prev_reg); end
      if (fire) void'(exp_q.pop_front());
      if (ek >= 0) begin
        p.id   = 3'(ek + 1);
        p.info = rob_info_mem[ek][rob_head[ek] % QD];
        p.data = reg_mem[exp_addr];
        p.vis  = cyc + 2;
        exp_q.push_back(p);
        ptr = (ek + 1) % NR;
      end
      prev_v   = (ek >= 0);
      prev_reg = exp_addr;
      if (cyc < 560) begin
        done_mask = 7'($urandom);
        ready_v   = ($urandom_range(0, 99) < 60);
        repeat (2) begin
          k = $urandom_range(0, NR - 1);
          if (rob_tail[k] - rob_head[k] < 8) push_rob(k, 5'($urandom), 20'($urandom));
        end
      end else begin
        done_mask = '0;
        ready_v   = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    rst             = 1'b1;
    rob_done_i      = '0;
    rob_reg_entry_i = '0;
    rob_info_i      = '0;
    reg_rd_data_i   = '0;
    out_ready_i     = 1'b0;
    for (int r = 0; r < 32; r++) reg_mem[r] = rand512();
    clear_env();
    @(negedge clk);
    test_reset();
    test_single_commit();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit_arbiter.md
Name: rob_commit_arbiter

Overview:
- Commit-side scheduler for the seven per-order-id ROBs (order ids 1..7).
- Each cycle it picks one ROB whose head entry has finished execution, round-robin, and pops that head.
- It reads the head's payload from the register file, frees the register, and delivers the packet in order per id on a valid/ready output port.
- Sits between the ROB/register files and the egress interface; it is the counterpart to decode's allocation.

Parameters:
info_length, 20, packet lookup side-band width
order_id, 3, order-id width
data_length, 512, payload width
register_num, 32, register file depth
num_rob, 7, number of ordered ROBs (ids 1..num_rob)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rob_done_i  in  num_rob  head entry of ROB k valid and execution complete
rob_reg_entry_i  in  num_rob*clogb(register_num)  register index of ROB k head, slice k
rob_info_i  in  num_rob*info_length  info of ROB k head, slice k
rob_rd_o  out  num_rob  one-hot pop pulse to ROB k
reg_rd_en_o  out  1  register file read strobe
reg_rd_addr_o  out  clogb(register_num)  read address
reg_rd_data_i  in  data_length  read data, valid the cycle after reg_rd_en_o
reg_free_o  out  1  release register pulse
reg_free_addr_o  out  clogb(register_num)  register being released
out_valid_o  out  1  output packet valid
out_ready_i  in  1  egress accepts
out_id_o  out  order_id  order id (k+1 for ROB k)
out_info_o  out  info_length  info
out_data_o  out  data_length  payload

Behaviour:
- Reset (sync, rst high at posedge): rr_ptr=0, s1_valid=0, output FIFO empty, occupancy=0. All outputs 0 during and after reset until the first grant.
- Arbitration (cycle T, combinational):
  - Candidates are the set bits of rob_done_i. Priority starts at index rr_ptr and rotates upward mod num_rob.
  - A grant is allowed only if (fifo_count + s1_valid − fire) < 2, where fire = out_valid_o & out_ready_i.
- Grant at T:
  - rob_rd_o[k]=1 for exactly one cycle.
  - reg_rd_en_o=1 and reg_rd_addr_o = slice k of rob_reg_entry_i.
  - rr_ptr <= (k+1) mod num_rob.
  - s1 captures id=k+1, info and register index.
- No grant: rob_rd_o=0, reg_rd_en_o=0, reg_rd_addr_o=0, rr_ptr held.
- Stage s1 (cycle T+1):
  - reg_rd_data_i is valid. reg_free_o=1 with reg_free_addr_o = s1 register index.
  - At the T+2 edge, {id, info, data} is pushed into the 2-entry output FIFO.
  - Space is guaranteed by the grant rule; an overflow never occurs and is asserted in simulation.
- Output: out_* shows the FIFO head.
  - Latency is 2 cycles from grant to out_valid_o when the FIFO is empty.
  - out_valid_o stays high and out_* stay stable until out_ready_i.
  - Throughput is 1 packet/cycle with out_ready_i held high.
- Simultaneous push and pop at the FIFO: the count is unchanged and ordering is preserved.
- Per-id ordering holds by construction: one head per ROB per grant, and a single pipeline.
- rob_done_i all zero: idle, no pulses.
- rr_ptr wraps 6 -> 0.
- Reset mid-operation: s1 and FIFO contents are discarded. No reg_free_o pulse is issued for a discarded s1, since the register file is reset alongside.
- All internal widths use clogb(). out_id_o = k+1 truncated to order_id bits.

Decomposition:
- Shared package holds clogb(), the default widths (info_length, order_id, data_length, register_num, num_rob) and derived localparams register_width and rob_width. decode uses the same package.
- One sub-module: commit_out_fifo, a 2-entry synchronous FIFO carrying {id, info, data}, with push/pop/count and a synchronous active-high reset.

Test Plan:
- Single commit: rob_done_i=7'b0000100, reg index 5, data 0xA5.. -> rob_rd_o[2] and reg_rd_addr_o=5 at T; reg_free_o with addr 5 at T+1; out_valid_o at T+2 with out_id_o=3 and data 0xA5...
- Round-robin: all 7 done, out_ready_i=1 for 10 cycles -> grant order 0,1,…,6,0,1,2, one per cycle, no gaps after start.
- Backpressure: out_ready_i=0 with 3 ROBs done -> exactly 2 grants, then rob_rd_o stays 0. Raise out_ready_i -> the third is granted, and outputs arrive in grant order with data intact.
- Full FIFO with simultaneous fire and grant: count=2 and out_ready_i=1 -> a grant occurs the same cycle and count stays ≤2.
- Reset mid-flight: rst asserted the cycle after a grant -> next cycle out_valid_o=0, reg_free_o=0, rr_ptr=0.
- Wrap: rr_ptr=6, rob_done_i bits 6 and 0 set -> grant 6, then 0.
